// File: rtl/mmio_uart_tx_pkg.sv
// uart_pkg: shared types and register offsets for the memory-mapped UART.
// Optional feature macro: MMIO_UART_PARITY_EN (adds an even-parity bit per frame).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Word offsets within the 16-byte register window (addr[3:2]).
    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty.
// The head entry is visible combinationally on dout so a consumer can pop
// and use the byte in the same cycle. Pops on empty and pushes on full
// (without a simultaneous pop) are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance; wrap-around falls out of the extra MSB.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers, cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-driven UART transmitter on the memory-stage bus.
// Stores to TXDATA queue bytes; the FSM sends them as 8N1 frames, or as
// 8E1 frames when MMIO_UART_PARITY_EN is defined (STATUS[4] then reads 1).
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int                    CLKS_PER_BIT = 868,
    parameter int                    FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  mem_write,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef MMIO_UART_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    uart_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            overflow_q, overflow_d;
`ifdef MMIO_UART_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [1:0]            offset;
    logic                  wr_txdata, wr_ctrl;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [7:0]            fifo_dout;
    logic                  baud_done;
    logic [DATA_WIDTH-1:0] status;
    logic                  unused_bits;

    assign offset    = addr[3:2];
    assign sel       = (addr[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
    assign wr_txdata = sel & mem_write & (offset == OFF_TXDATA);
    assign wr_ctrl   = sel & mem_write & (offset == OFF_CTRL);
    assign fifo_pop  = (state_q == IDLE) & ~fifo_empty;
    assign baud_done = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;
    assign unused_bits = ^{addr[1:0], wdata[DATA_WIDTH-1:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // STATUS view and read mux; every other offset reads zero.
    always_comb begin
        status    = '0;
        status[0] = fifo_full;
        status[1] = fifo_empty;
        status[2] = (state_q != IDLE);
        status[3] = overflow_q;
        status[4] = PARITY_FLAG;
        rdata     = (sel && offset == OFF_STATUS) ? status : '0;
    end

    // Next-state logic for the frame sequencer, baud counter and overflow flag.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        overflow_d = overflow_q;
`ifdef MMIO_UART_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (fifo_pop) begin
                    shift_d = fifo_dout;
                    bit_d   = 3'd0;
                    state_d = START;
`ifdef MMIO_UART_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                end
            end
            START: if (baud_done) state_d = DATA;
            DATA: begin
                if (baud_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: if (baud_done) state_d = STOP;
`endif
            STOP: if (baud_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter restarts on every state change and idles at zero.
        if (state_d != state_q || state_q == IDLE) cnt_d = '0;
        else                                       cnt_d = cnt_q + CW'(1);

        // Line level is registered from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase

        // Clear first so a same-cycle overflow event takes priority.
        if (wr_ctrl && wdata[0])                     overflow_d = 1'b0;
        if (wr_txdata && fifo_full && !fifo_pop)     overflow_d = 1'b1;
    end

    // All sequencer state, registered tx and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
`ifdef MMIO_UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Honours MMIO_UART_PARITY_EN to expect 8E1 frames and STATUS[4]=1.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef MMIO_UART_PARITY_EN
    localparam logic [31:0] PBIT = 32'h10;
`else
    localparam logic [31:0] PBIT = 32'h0;
`endif
    localparam logic [31:0] ST_IDLE = 32'h2 | PBIT;   // empty, idle
    localparam logic [31:0] ST_BUSY = 32'h6 | PBIT;   // empty, busy

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;

    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  rx_q[$];
    logic        par_q[$];

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .DATA_WIDTH   (32),
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .mem_write (mem_write),
        .sel       (sel),
        .rdata     (rdata),
        .tx        (tx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; mem_write = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_idle();
        mem_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_sel, input string tag);
        mem_write = 1'b0; addr = a;
        #1;
        check(tag, rdata, exp_d);
        check({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("rx_count", 32'(rx_q.size()), 32'(n));
    endtask

    // Cycle-exact line check, starting on the first START sample.
    task automatic frame_exact(input logic [7:0] b, input string tag);
        for (int j = 0; j < 4; j++) begin
            check({tag, "_start"}, 32'(tx), 32'd0);
            if (j == 0) rd_chk(BASE + 32'h4, ST_BUSY, 1'b1, {tag, "_busy"});
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) begin
                check({tag, "_data"}, 32'(tx), 32'(b[i]));
                @(negedge clk);
            end
`ifdef MMIO_UART_PARITY_EN
        for (int j = 0; j < 4; j++) begin
            check({tag, "_parity"}, 32'(tx), 32'(^b));
            @(negedge clk);
        end
`endif
        for (int j = 0; j < 4; j++) begin
            check({tag, "_stop"}, 32'(tx), 32'd1);
            @(negedge clk);
        end
    endtask

    // Line receiver: samples each bit one cycle after its start.
    initial begin : monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && rst && tx === 1'b0) begin
                repeat (5) @(negedge clk);
                b[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
`ifdef MMIO_UART_PARITY_EN
                repeat (4) @(negedge clk);
                par_q.push_back(tx);
`endif
                repeat (4) @(negedge clk);
                check("stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(b);
                $display("rx byte %h", b);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        // Reset state.
        addr = BASE + 32'h4;
        repeat (2) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "rst_status");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "post_rst_status");

        // Asynchronous reset in the middle of a frame.
        st(BASE, 32'h55);
        bus_idle();
        repeat (10) @(negedge clk);
        rd_chk(BASE + 32'h4, ST_BUSY, 1'b1, "midframe_busy");
        #1 rst = 1'b0;
        #1 check("async_rst_tx", 32'(tx), 32'd1);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "in_rst_status");
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("after_rst_tx", 32'(tx), 32'd1);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "after_rst_status");
        $display("reset tests done");

        // Single frame 0xA5 with exact timing.
        mon_en = 1'b1;
        st(BASE, 32'h0000_00A5);
        bus_idle();
        check("latency_hold", 32'(tx), 32'd1);
        @(negedge clk);
        frame_exact(8'hA5, "a5");
        check("a5_idle_tx", 32'(tx), 32'd1);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "a5_done_status");
        check("a5_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("a5_rx_byte", 32'(rx_q[0]), 32'hA5);
        rx_q.delete();
        par_q.delete();
        $display("frame 0xA5 done");

        // Fill past capacity: first byte popped at once, four queued, sixth dropped.
        for (int i = 1; i <= 6; i++) st(BASE, 32'(i));
        bus_idle();
        rd_chk(BASE + 32'h4, 32'hD | PBIT, 1'b1, "overflow_status");

        // CTRL with bit0 clear leaves overflow; bit0 set clears it.
        st(BASE + 32'h8, 32'h0);
        bus_idle();
        rd_chk(BASE + 32'h4, 32'hD | PBIT, 1'b1, "ctrl0_keeps_ovf");
        st(BASE + 32'h8, 32'h1);
        bus_idle();
        rd_chk(BASE + 32'h4, 32'h5 | PBIT, 1'b1, "ctrl1_clears_ovf");
        st(BASE, 32'h66);
        bus_idle();
        rd_chk(BASE + 32'h4, 32'hD | PBIT, 1'b1, "ovf_reassert");
        st(BASE + 32'h8, 32'hFFFF_FFFF);
        bus_idle();
        rd_chk(BASE + 32'h4, 32'h5 | PBIT, 1'b1, "ovf_clear_again");

        wait_rx(5, 400);
        for (int i = 0; i < 5; i++)
            if (rx_q.size() > i) check("order_byte", 32'(rx_q[i]), 32'(i + 1));
        rx_q.delete();
        par_q.delete();
        repeat (10) @(negedge clk);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "drained_status");
        $display("fifo/overflow tests done");

        // Decode boundaries.
        rd_chk(BASE + 32'hC, 32'h0, 1'b1, "reserved_read");
        rd_chk(32'h0000_0004, 32'h0, 1'b0, "outside_read");
        rd_chk(BASE, 32'h0, 1'b1, "txdata_read");
        rd_chk(BASE + 32'h8, 32'h0, 1'b1, "ctrl_read");
        st(BASE + 32'h4, 32'h77);
        st(32'h0000_0000, 32'h78);
        st(BASE + 32'hC, 32'h79);
        bus_idle();
        repeat (3) @(negedge clk);
        check("no_push_tx", 32'(tx), 32'd1);
        rd_chk(BASE + 32'h4, ST_IDLE, 1'b1, "no_push_status");
        st(BASE + 32'h3, 32'h1234_56C3);
        bus_idle();
        wait_rx(1, 100);
        if (rx_q.size() > 0) check("unaligned_byte", 32'(rx_q[0]), 32'hC3);
        rx_q.delete();
        par_q.delete();
        $display("decode tests done");

`ifdef MMIO_UART_PARITY_EN
        // Parity bits: 0x07 has three ones, 0x03 has two.
        repeat (10) @(negedge clk);
        st(BASE, 32'h07);
        st(BASE, 32'h03);
        bus_idle();
        wait_rx(2, 200);
        if (rx_q.size() > 1) begin
            check("par_byte0", 32'(rx_q[0]), 32'h07);
            check("par_byte1", 32'(rx_q[1]), 32'h03);
        end
        if (par_q.size() > 1) begin
            check("parity_07", 32'(par_q[0]), 32'd1);
            check("parity_03", 32'(par_q[1]), 32'd0);
        end
        $display("parity tests done");
`endif

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
